// File: rtl/monolith_round_ctrl.sv
// Round sequencer for the Monolith permutation over M31: holds the working state and round
// counter, and launches NUM_ROUNDS+1 passes through an external single-round datapath.
module monolith_round_ctrl #(
    parameter int WORD_WIDTH = 31,
    parameter int STATE_SIZE = 16,
    parameter int NUM_ROUNDS = 6,
    parameter int ROUND_W    = $clog2(NUM_ROUNDS + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [WORD_WIDTH-1:0] in_state     [0:STATE_SIZE-1],
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [WORD_WIDTH-1:0] out_state    [0:STATE_SIZE-1],
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WORD_WIDTH-1:0] dp_state_out [0:STATE_SIZE-1],
    output logic                  dp_valid,
    output logic [ROUND_W-1:0]    dp_round,
    output logic                  dp_init,
    input  logic [WORD_WIDTH-1:0] dp_state_in  [0:STATE_SIZE-1],
    input  logic                  dp_done,
    output logic                  busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_WAIT   = 2'd2,
        S_OUTPUT = 2'd3
    } state_t;

    localparam logic [ROUND_W-1:0] LAST_RND = ROUND_W'(NUM_ROUNDS);

    state_t                state_q;
    state_t                state_d;
    logic [WORD_WIDTH-1:0] st [0:STATE_SIZE-1];
    logic [ROUND_W-1:0]    rnd;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Working state is only written on an accept or a datapath return while waiting.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rnd <= '0;
            for (int i = 0; i < STATE_SIZE; i++) begin
                st[i] <= '0;
            end
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        st  <= in_state;
                        rnd <= '0;
                    end
                end
                S_WAIT: begin
                    if (dp_done) begin
                        st <= dp_state_in;
                        if (rnd != LAST_RND) begin
                            rnd <= rnd + 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        dp_valid  = 1'b0;
        dp_round  = '0;
        dp_init   = 1'b0;
        busy      = (state_q != S_IDLE);
        unique case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                dp_valid = 1'b1;
                dp_round = rnd;
                dp_init  = (rnd == '0);
                state_d  = S_WAIT;
            end
            S_WAIT: begin
                if (dp_done) begin
                    state_d = (rnd == LAST_RND) ? S_OUTPUT : S_ISSUE;
                end
            end
            S_OUTPUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Both state views come straight from the register; no input reaches them combinationally.
    assign dp_state_out = st;
    assign out_state    = st;

endmodule

// File: tb/tb_monolith_round_ctrl.sv
// Randomised self-checking bench for monolith_round_ctrl: a responder models the round
// datapath and a cycle-timing model predicts every output from the accept cycle and latency.
module tb_monolith_round_ctrl;

    localparam int W  = 31;
    localparam int S  = 16;
    localparam int N  = 6;
    localparam int RW = 3;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] in_state     [0:S-1];
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] out_state    [0:S-1];
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] dp_state_out [0:S-1];
    logic         dp_valid;
    logic [RW-1:0] dp_round;
    logic         dp_init;
    logic [W-1:0] dp_state_in  [0:S-1];
    logic         dp_done;
    logic         busy;

    logic [W-1:0] resp_state [0:S-1];
    logic         resp_done;
    logic         spur_done;
    logic         spur_issue;
    int           lat;
    int           mode;
    bit           chk_en;

    int n_chk = 0;
    int n_pass = 0;
    int dpv_total = 0;
    int init_total = 0;

    bit           m_act;
    bit           m_zero;
    int           m_t;
    logic [W-1:0] exp_mid [0:N+1][0:S-1];

    always #5 clk = ~clk;

    assign dp_done = resp_done | spur_done;
    always_comb begin
        for (int i = 0; i < S; i++) begin
            dp_state_in[i] = resp_done ? resp_state[i] : (31'h2aaaaaaa ^ W'(i));
        end
    end

    monolith_round_ctrl #(
        .WORD_WIDTH(W),
        .STATE_SIZE(S),
        .NUM_ROUNDS(N),
        .ROUND_W(RW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_state(in_state),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .out_state(out_state),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .dp_state_out(dp_state_out),
        .dp_valid(dp_valid),
        .dp_round(dp_round),
        .dp_init(dp_init),
        .dp_state_in(dp_state_in),
        .dp_done(dp_done),
        .busy(busy)
    );

    // One round of the stand-in datapath for each test mode.
    function automatic logic [W-1:0] fword(input logic [W-1:0] w, input int r, input bit init,
                                           input int idx, input int md);
        logic [W-1:0] rr;
        rr = W'(r);
        case (md)
            0:       return w;
            1:       return w + rr;
            default: return init ? ((w ^ 31'h15a5a5a5) + W'(idx))
                                 : ({w[W-2:0], w[W-1]} ^ (rr * 31'h0123457) ^ W'(idx * 7));
        endcase
    endfunction

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        n_chk++;
        if (a === e) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, a, e, $time);
    endtask

    // Datapath responder: answers each launch exactly lat cycles later.
    initial begin : responder
        logic [W-1:0] v [0:S-1];
        resp_done = 1'b0;
        for (int i = 0; i < S; i++) resp_state[i] = '0;
        forever begin
            @(negedge clk);
            if (dp_valid) begin
                for (int i = 0; i < S; i++) v[i] = fword(dp_state_out[i], int'(dp_round), dp_init, i, mode);
                if (spur_issue) begin
                    for (int i = 0; i < S; i++) resp_state[i] = W'($urandom);
                    resp_done = 1'b1;
                end
                @(posedge clk); #1;
                resp_done = 1'b0;
                for (int j = 1; j < lat; j++) begin
                    @(posedge clk); #1;
                end
                resp_state = v;
                resp_done  = 1'b1;
                @(posedge clk); #1;
                resp_done = 1'b0;
            end
        end
    end

    // Behavioural model: cycle index since accept plus the whole chain of pass results.
    initial begin : model
        m_act = 1'b0;
        m_zero = 1'b1;
        m_t = 0;
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                m_act  = 1'b0;
                m_zero = 1'b1;
            end else if (!m_act) begin
                if (in_valid) begin
                    m_act  = 1'b1;
                    m_zero = 1'b0;
                    m_t    = 1;
                    for (int i = 0; i < S; i++) exp_mid[0][i] = in_state[i];
                    for (int r = 0; r <= N; r++)
                        for (int i = 0; i < S; i++)
                            exp_mid[r+1][i] = fword(exp_mid[r][i], r, r == 0, i, mode);
                end
            end else begin
                if (m_t >= 1 + (N + 1) * (lat + 1) && out_ready) m_act = 1'b0;
                else m_t++;
            end
        end
    end

    initial begin : compare
        int k;
        bit dpv_e;
        bit ov_e;
        forever begin
            @(negedge clk);
            if (dp_valid) begin
                dpv_total++;
                if (dp_init) init_total++;
            end
            if (chk_en) begin
                k = 0;
                dpv_e = 1'b0;
                ov_e = 1'b0;
                if (m_act) begin
                    k     = (m_t - 1) / (lat + 1);
                    dpv_e = ((m_t - 1) % (lat + 1) == 0) && (k <= N);
                    ov_e  = (m_t >= 1 + (N + 1) * (lat + 1));
                end
                chk("in_ready", 64'(in_ready), 64'(!m_act));
                chk("busy", 64'(busy), 64'(m_act));
                chk("dp_valid", 64'(dp_valid), 64'(dpv_e));
                chk("dp_round", 64'(dp_round), dpv_e ? 64'(k) : 64'd0);
                chk("dp_init", 64'(dp_init), 64'(dpv_e && k == 0));
                chk("out_valid", 64'(out_valid), 64'(ov_e));
                if (dpv_e)
                    for (int i = 0; i < S; i++)
                        chk($sformatf("dp_state_out[%0d]", i), 64'(dp_state_out[i]), 64'(exp_mid[k][i]));
                if (ov_e)
                    for (int i = 0; i < S; i++)
                        chk($sformatf("out_state[%0d]", i), 64'(out_state[i]), 64'(exp_mid[N+1][i]));
                if (m_zero)
                    for (int i = 0; i < S; i++) begin
                        chk($sformatf("zero dp_state_out[%0d]", i), 64'(dp_state_out[i]), 64'd0);
                        chk($sformatf("zero out_state[%0d]", i), 64'(out_state[i]), 64'd0);
                    end
            end
        end
    end

    task automatic start_perm();
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 400);
        chk("wait_out_valid", 64'(out_valid), 64'd1);
    endtask

    task automatic release_out(input int hold);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            in_valid  = i[0];
            spur_done = i[1];
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        spur_done = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("in_ready_after_release", 64'(in_ready), 64'd1);
    endtask

    initial begin : main
        int n;
        int d0;
        int i0;
        bit found;
        reset = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        spur_done = 1'b0;
        spur_issue = 1'b0;
        lat = 1;
        mode = 0;
        chk_en = 1'b0;
        for (int i = 0; i < S; i++) in_state[i] = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset in_ready", 64'(in_ready), 64'd1);
        chk("reset out_valid", 64'(out_valid), 64'd0);
        chk("reset dp_valid", 64'(dp_valid), 64'd0);
        chk("reset dp_round", 64'(dp_round), 64'd0);
        chk("reset dp_init", 64'(dp_init), 64'd0);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset out_state[7]", 64'(out_state[7]), 64'd0);
        chk("reset dp_state_out[7]", 64'(dp_state_out[7]), 64'd0);
        chk_en = 1'b1;
        reset = 1'b1;

        // Spurious datapath return while idle.
        @(posedge clk); #1;
        spur_done = 1'b1;
        @(posedge clk); #1;
        spur_done = 1'b0;
        @(posedge clk); #1;

        // Identity datapath, L=1, then a long backpressure hold.
        mode = 0;
        lat = 1;
        for (int i = 0; i < S; i++) in_state[i] = W'(i);
        d0 = dpv_total;
        i0 = init_total;
        start_perm();
        wait_out(n);
        chk("t1 out cycle", 64'(n), 64'd15);
        for (int i = 0; i < S; i++) chk($sformatf("t1 out_state[%0d]", i), 64'(out_state[i]), 64'(i));
        chk("t1 dp pulses", 64'(dpv_total - d0), 64'd7);
        chk("t1 init pulses", 64'(init_total - i0), 64'd1);
        release_out(10);

        // Round-index adder, L=3, with spurious returns during ISSUE.
        mode = 1;
        lat = 3;
        spur_issue = 1'b1;
        for (int i = 0; i < S; i++) in_state[i] = W'(i);
        start_perm();
        wait_out(n);
        chk("t2 out cycle", 64'(n), 64'd29);
        for (int i = 0; i < S; i++) chk($sformatf("t2 out_state[%0d]", i), 64'(out_state[i]), 64'(i + 21));
        release_out(0);

        // Randomised permutations.
        mode = 2;
        for (int p = 0; p < 8; p++) begin
            lat = $urandom_range(1, 5);
            spur_issue = 1'($urandom_range(0, 1));
            for (int i = 0; i < S; i++) in_state[i] = W'($urandom);
            start_perm();
            wait_out(n);
            release_out($urandom_range(0, 3));
        end
        spur_issue = 1'b0;

        // Reset while waiting on round 3; the late datapath return must be ignored.
        lat = 4;
        for (int i = 0; i < S; i++) in_state[i] = W'($urandom);
        start_perm();
        found = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (dp_valid && dp_round == 3'd3) begin
                found = 1'b1;
                break;
            end
        end
        chk("reset test reached round 3", 64'(found), 64'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk("abort in_ready", 64'(in_ready), 64'd1);
        chk("abort busy", 64'(busy), 64'd0);
        chk("abort dp_valid", 64'(dp_valid), 64'd0);
        chk("abort out_valid", 64'(out_valid), 64'd0);
        chk("abort dp_state_out[0]", 64'(dp_state_out[0]), 64'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        lat = 2;
        for (int i = 0; i < S; i++) in_state[i] = W'($urandom);
        start_perm();
        wait_out(n);
        chk("post-reset out cycle", 64'(n), 64'(1 + 7 * 3));
        release_out(1);

        // Back-to-back with out_ready held high.
        out_ready = 1'b1;
        lat = 1;
        for (int i = 0; i < S; i++) in_state[i] = W'($urandom);
        start_perm();
        wait_out(n);
        @(posedge clk); #1;
        chk("b2b in_ready", 64'(in_ready), 64'd1);
        for (int i = 0; i < S; i++) in_state[i] = W'($urandom);
        start_perm();
        wait_out(n);
        chk("b2b second out cycle", 64'(n), 64'd15);
        @(posedge clk); #1;
        out_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
